// File: rtl/timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : timer_ctrl
//  Purpose  : Control block for an 8-bit timer. Runs a free-running prescaler
//             that produces the count clock, tracks run/reload state, and
//             detects counter overflow/underflow from the counter datapath,
//             raising sticky flags and a combined interrupt.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DIV_W          prescaler width (max divide ratio 2^DIV_W), default 4
//  Ports
//    pclk           in   system clock (only clock)
//    preset_n       in   synchronous active-low reset
//    tcr[7:0]       in   [7] load, [4] enable, [3] down, [1:0] clock select
//    tier[1:0]      in   interrupt enable: [0] overflow, [1] underflow
//    counter_value  in   current counter value
//    last_counter   in   counter value delayed by one pclk
//    clr_ovf        in   write-1-to-clear for tmr_ovf
//    clr_udf        in   write-1-to-clear for tmr_udf
//    clk_in         out  count clock to the counter datapath
//    reload         out  one-cycle load request to the counter
//    tmr_ovf        out  sticky overflow flag
//    tmr_udf        out  sticky underflow flag
//    irq            out  combined interrupt
//  Configuration macro
//    TIMER_CTRL_AUTORELOAD_EN  enables the RELOAD state and reload pulse;
//                              when undefined reload is tied to 0.
// ============================================================================
module timer_ctrl #(
  parameter int DIV_W = 4
) (
  input  logic       pclk,
  input  logic       preset_n,
  input  logic [7:0] tcr,
  input  logic [1:0] tier,
  input  logic [7:0] counter_value,
  input  logic [7:0] last_counter,
  input  logic       clr_ovf,
  input  logic       clr_udf,
  output logic       clk_in,
  output logic       reload,
  output logic       tmr_ovf,
  output logic       tmr_udf,
  output logic       irq
);

  localparam logic [1:0]       IDLE    = 2'd0;
  localparam logic [1:0]       RUN     = 2'd1;
  localparam logic [1:0]       RELOAD  = 2'd2;
  localparam logic [DIV_W-1:0] DIV_ONE = 1;

  logic             load;
  logic             enable;
  logic             down;
  logic [1:0]       sel;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       tap;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             ovf_evt;
  logic             udf_evt;
  logic             unused_tcr_bits;

  assign load            = tcr[7];
  assign enable          = tcr[4];
  assign down            = tcr[3];
  assign sel             = tcr[1:0];
  assign unused_tcr_bits = ^{tcr[6:5], tcr[2]};

  // --------------------------------------------------------------------------
  // Prescaler: free-running, held at zero while load is asserted so the
  // count clock restarts phase-aligned once the load is released.
  // --------------------------------------------------------------------------
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      div_cnt <= '0;
    end else if (load) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
    end
  end

  // Select taps are always 4 wide; a narrower prescaler pads with zeros so
  // an out-of-range select yields a quiet (stuck-low) count clock.
  generate
    if (DIV_W >= 4) begin : g_tap_full
      assign tap = div_cnt[3:0];
    end else begin : g_tap_pad
      assign tap = {{(4 - DIV_W){1'b0}}, div_cnt};
    end
  endgenerate

  // Registered tap; a select change simply takes effect on the next sample.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      clk_in <= 1'b0;
    end else begin
      clk_in <= tap[sel];
    end
  end

  // --------------------------------------------------------------------------
  // Wrap detection: only meaningful while counting, so loads performed in
  // IDLE never masquerade as an overflow/underflow.
  // --------------------------------------------------------------------------
  assign ovf_evt = (state == RUN) && !down &&
                   (last_counter == 8'hFF) && (counter_value == 8'h00);
  assign udf_evt = (state == RUN) && down &&
                   (last_counter == 8'h00) && (counter_value == 8'hFF);

  // Sticky flags: a new event wins over a simultaneous clear.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      tmr_ovf <= 1'b0;
      tmr_udf <= 1'b0;
    end else begin
      if (ovf_evt) begin
        tmr_ovf <= 1'b1;
      end else if (clr_ovf) begin
        tmr_ovf <= 1'b0;
      end
      if (udf_evt) begin
        tmr_udf <= 1'b1;
      end else if (clr_udf) begin
        tmr_udf <= 1'b0;
      end
    end
  end

  assign irq = (tmr_ovf & tier[0]) | (tmr_udf & tier[1]);

  // --------------------------------------------------------------------------
  // State machine. The wrap event is registered once before it moves the
  // FSM, so RELOAD (and the reload pulse) lands two cycles after the wrap
  // pattern is presented.
  // --------------------------------------------------------------------------
`ifdef TIMER_CTRL_AUTORELOAD_EN
  logic wrap_q;

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= ovf_evt | udf_evt;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable && !load) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!enable || load) begin
          state_nxt = IDLE;
        end
`ifdef TIMER_CTRL_AUTORELOAD_EN
        else if (wrap_q) begin
          state_nxt = RELOAD;
        end
`endif
      end
      RELOAD: begin
        // The pulse always completes; a dropped enable just skips RUN.
        state_nxt = enable ? RUN : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef TIMER_CTRL_AUTORELOAD_EN
  // Registered alongside the state so reload is high exactly while in RELOAD.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      reload <= 1'b0;
    end else begin
      reload <= (state_nxt == RELOAD);
    end
  end
`else
  assign reload = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timer_ctrl
//  Purpose  : Directed self-checking bench for timer_ctrl: reset values,
//             clock select, overflow/underflow flags, irq masking, auto-reload
//             timing and abort, load/disable behaviour and mid-run reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_timer_ctrl;

`ifdef TIMER_CTRL_AUTORELOAD_EN
  localparam logic AR = 1'b1;
`else
  localparam logic AR = 1'b0;
`endif

  logic       pclk;
  logic       preset_n;
  logic [7:0] tcr;
  logic [1:0] tier;
  logic [7:0] counter_value;
  logic [7:0] last_counter;
  logic       clr_ovf;
  logic       clr_udf;
  logic       clk_in;
  logic       reload;
  logic       tmr_ovf;
  logic       tmr_udf;
  logic       irq;

  int tests_run;
  int tests_failed;

  timer_ctrl #(.DIV_W(4)) dut (
    .pclk          (pclk),
    .preset_n      (preset_n),
    .tcr           (tcr),
    .tier          (tier),
    .counter_value (counter_value),
    .last_counter  (last_counter),
    .clr_ovf       (clr_ovf),
    .clr_udf       (clr_udf),
    .clk_in        (clk_in),
    .reload        (reload),
    .tmr_ovf       (tmr_ovf),
    .tmr_udf       (tmr_udf),
    .irq           (irq)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Advance one pclk edge and settle just after it.
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_clk;
    tests_run     = 0;
    tests_failed  = 0;
    preset_n      = 1'b0;
    tcr           = 8'h00;
    tier          = 2'b01;
    counter_value = 8'h10;
    last_counter  = 8'h0F;
    clr_ovf       = 1'b0;
    clr_udf       = 1'b0;

    // Reset values
    #1;
    step();
    step();
    check("rst_clk_in", clk_in, 1'b0);
    check("rst_reload", reload, 1'b0);
    check("rst_ovf", tmr_ovf, 1'b0);
    check("rst_udf", tmr_udf, 1'b0);
    check("rst_irq", irq, 1'b0);

    // Clock select 2: after edge k from reset, clk_in = bit2 of (k-1)
    preset_n = 1'b1;
    tcr      = 8'h12;
    for (int k = 1; k <= 21; k++) begin
      step();
      exp_clk = (((k - 1) >> 2) & 1) != 0;
      check("div8_clk_in", clk_in, exp_clk);
    end
    // clk_in is high here; reset must drop it on the next edge
    preset_n = 1'b0;
    step();
    check("rst_clk_in_mid", clk_in, 1'b0);

    // Overflow in RUN, up-counting, irq enabled for overflow
    preset_n = 1'b1;
    tcr      = 8'h10;
    step();                                   // IDLE -> RUN
    last_counter = 8'hFE; counter_value = 8'hFF;
    step();
    check("no_ovf_FE_FF", tmr_ovf, 1'b0);
    last_counter = 8'hFF; counter_value = 8'h00;
    step();
    check("ovf_set", tmr_ovf, 1'b1);
    check("ovf_irq", irq, 1'b1);
    check("reload_not_yet", reload, 1'b0);
    last_counter = 8'h00; counter_value = 8'h01;
    step();
    check("reload_pulse", reload, AR);
    check("ovf_sticky", tmr_ovf, 1'b1);
    step();
    check("reload_one_cycle", reload, 1'b0);
    clr_ovf = 1'b1;
    step();
    check("ovf_cleared", tmr_ovf, 1'b0);
    check("irq_cleared", irq, 1'b0);
    clr_ovf = 1'b0;

    // Second overflow proves FSM is back in RUN; irq masked for overflow
    tier = 2'b10;
    last_counter = 8'hFF; counter_value = 8'h00;
    step();
    check("ovf_again", tmr_ovf, 1'b1);
    check("irq_masked", irq, 1'b0);
    last_counter = 8'h00; counter_value = 8'h01;
    step();
    check("reload_pulse2", reload, AR);
    // Drop enable during RELOAD: pulse completes, FSM goes to IDLE
    tcr = 8'h00;
    step();
    check("reload_abort_end", reload, 1'b0);
    clr_ovf = 1'b1;
    step();
    check("ovf_cleared2", tmr_ovf, 1'b0);
    clr_ovf = 1'b0;
    // Wrap pattern while disabled must be ignored
    last_counter = 8'hFF; counter_value = 8'h00;
    step();
    check("idle_no_ovf", tmr_ovf, 1'b0);
    step();
    check("idle_no_ovf2", tmr_ovf, 1'b0);
    check("idle_no_reload", reload, 1'b0);

    // Load holds prescaler at 0; sel=3 then gives first high at edge 9
    tcr = 8'h93;
    step();
    step();
    check("load_clk_in", clk_in, 1'b0);
    check("load_no_ovf", tmr_ovf, 1'b0);
    last_counter = 8'h00; counter_value = 8'h01;
    tcr = 8'h13;
    for (int k = 1; k <= 8; k++) begin
      step();
    end
    check("div16_low_k8", clk_in, 1'b0);
    step();
    check("div16_high_k9", clk_in, 1'b1);

    // Overflow in RUN (sel=3, up) to set tmr_ovf, let any reload finish
    last_counter = 8'hFF; counter_value = 8'h00;
    step();
    check("ovf_set3", tmr_ovf, 1'b1);
    last_counter = 8'h00; counter_value = 8'h01;
    step();
    step();
    step();

    // Underflow with simultaneous clear: set wins
    tcr = 8'h18;
    last_counter = 8'h00; counter_value = 8'hFF; clr_udf = 1'b1;
    step();
    check("udf_set_wins", tmr_udf, 1'b1);
    check("udf_irq", irq, 1'b1);
    clr_udf = 1'b0;
    last_counter = 8'hFF; counter_value = 8'hFE;
    step();
    check("udf_reload", reload, AR);
    check("ovf_still_set", tmr_ovf, 1'b1);

    // Reset during RELOAD with both flags set
    preset_n = 1'b0;
    step();
    check("midrst_reload", reload, 1'b0);
    check("midrst_ovf", tmr_ovf, 1'b0);
    check("midrst_udf", tmr_udf, 1'b0);
    check("midrst_irq", irq, 1'b0);
    check("midrst_clk_in", clk_in, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
